// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
//   word_t      : 32-bit datapath word
//   regbits_t   : 5-bit architectural register index
//   aluop_t     : ALU operation select (ALU_SLL encodes as 0)
//   ext_t       : immediate extension mode for the issue stage
//   alu_srcb_t  : ALU B-operand source for the issue stage
//   issue_slot_t: one resolved ALU issue (operands + op)
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_SRA  = 4'd10
  } aluop_t;

  typedef enum logic [1:0] {
    EXT_ZERO = 2'd0,
    EXT_SIGN = 2'd1,
    EXT_LUI  = 2'd2
  } ext_t;

  typedef enum logic [1:0] {
    SRCB_RT    = 2'd0,
    SRCB_IMM   = 2'd1,
    SRCB_SHAMT = 2'd2
  } alu_srcb_t;

  typedef struct packed {
    word_t  porta;
    word_t  portb;
    aluop_t op;
  } issue_slot_t;

  // Expand a 16-bit immediate to a full word according to the extension mode.
  function automatic word_t extend_imm(input ext_t sel, input logic [15:0] imm);
    word_t res;
    case (sel)
      EXT_ZERO: res = {16'h0000, imm};
      EXT_SIGN: res = {{16{imm[15]}}, imm};
      EXT_LUI:  res = {imm, 16'h0000};
      default:  res = 32'h0000_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_if.sv
// ALU operand interface.
//   porta, portb : ALU operands
//   ALUOP        : ALU operation
// The tb modport is the driving side (issue stage); the alu modport consumes.
interface alu_if;
  import cpu_types_pkg::*;

  word_t  porta;
  word_t  portb;
  aluop_t ALUOP;

  modport tb  (output porta, output portb, output ALUOP);
  modport alu (input  porta, input  portb, input  ALUOP);

endinterface

// File: rtl/operand_fwd.sv
// Operand forwarding mux for one source register.
//   i_idx              : source register index
//   i_rf_data          : register-file read value
//   i_mem_wen/wsel/wdat: MEM-stage writeback candidate (highest priority)
//   i_wb_wen/wsel/wdat : WB-stage writeback candidate
//   o_data             : resolved operand value
// Register 0 is hardwired, so it is never forwarded.
module operand_fwd
  import cpu_types_pkg::*;
(
  input  regbits_t i_idx,
  input  word_t    i_rf_data,
  input  logic     i_mem_wen,
  input  regbits_t i_mem_wsel,
  input  word_t    i_mem_wdat,
  input  logic     i_wb_wen,
  input  regbits_t i_wb_wsel,
  input  word_t    i_wb_wdat,
  output word_t    o_data
);

  logic w_nonzero;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_nonzero = (i_idx != 5'd0);
  assign w_mem_hit = i_mem_wen && (i_mem_wsel == i_idx) && w_nonzero;
  assign w_wb_hit  = i_wb_wen  && (i_wb_wsel  == i_idx) && w_nonzero;

  // Priority select: the younger MEM result wins over WB.
  always_comb begin
    o_data = i_rf_data;
    if (w_mem_hit) begin
      o_data = i_mem_wdat;
    end else if (w_wb_hit) begin
      o_data = i_wb_wdat;
    end else begin
      o_data = i_rf_data;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: resolves forwarded operands at accept time and presents
// them to the ALU through a one-deep output register backed by a skid entry.
//   CLK, RST              : clock, async active-high reset
//   in_valid / in_ready   : upstream handshake (in_ready = skid empty, registered)
//   rs, rt, rs_data, rt_data : source indices and register-file values
//   imm16, shamt, ext_sel, asel, bsel, aluop_in : operand construction controls
//   mem_* / wb_*          : forwarding sources
//   flush                 : drop everything held, overrides accept
//   out_valid / out_ready : downstream handshake
//   porta, portb, ALUOP   : ALU operands and op (via an alu_if instance)
module alu_issue_stage
  import cpu_types_pkg::*;
(
  input  logic      CLK,
  input  logic      RST,
  input  logic      in_valid,
  output logic      in_ready,
  input  regbits_t  rs,
  input  regbits_t  rt,
  input  word_t     rs_data,
  input  word_t     rt_data,
  input  logic [15:0] imm16,
  input  logic [4:0]  shamt,
  input  ext_t      ext_sel,
  input  logic      asel,
  input  alu_srcb_t bsel,
  input  aluop_t    aluop_in,
  input  logic      mem_wen,
  input  regbits_t  mem_wsel,
  input  word_t     mem_wdat,
  input  logic      wb_wen,
  input  regbits_t  wb_wsel,
  input  word_t     wb_wdat,
  input  logic      flush,
  output logic      out_valid,
  input  logic      out_ready,
  output word_t     porta,
  output word_t     portb,
  output aluop_t    ALUOP
);

  word_t       w_rs_fwd;
  word_t       w_rt_fwd;
  word_t       w_imm_ext;
  issue_slot_t w_new;
  logic        w_accept;
  logic        w_xfer;

  issue_slot_t r_out;
  logic        r_out_valid;
  issue_slot_t r_skid;
  logic        r_skid_valid;

  issue_slot_t w_out_nxt;
  logic        w_out_valid_nxt;
  issue_slot_t w_skid_nxt;
  logic        w_skid_valid_nxt;

  operand_fwd u_fwd_rs (
    .i_idx      (rs),
    .i_rf_data  (rs_data),
    .i_mem_wen  (mem_wen),
    .i_mem_wsel (mem_wsel),
    .i_mem_wdat (mem_wdat),
    .i_wb_wen   (wb_wen),
    .i_wb_wsel  (wb_wsel),
    .i_wb_wdat  (wb_wdat),
    .o_data     (w_rs_fwd)
  );

  operand_fwd u_fwd_rt (
    .i_idx      (rt),
    .i_rf_data  (rt_data),
    .i_mem_wen  (mem_wen),
    .i_mem_wsel (mem_wsel),
    .i_mem_wdat (mem_wdat),
    .i_wb_wen   (wb_wen),
    .i_wb_wsel  (wb_wsel),
    .i_wb_wdat  (wb_wdat),
    .o_data     (w_rt_fwd)
  );

  // Build the resolved issue slot for the instruction currently offered.
  always_comb begin
    w_imm_ext   = extend_imm(ext_sel, imm16);
    w_new.op    = aluop_in;
    w_new.porta = asel ? w_rt_fwd : w_rs_fwd;
    case (bsel)
      SRCB_RT:    w_new.portb = w_rt_fwd;
      SRCB_IMM:   w_new.portb = w_imm_ext;
      SRCB_SHAMT: w_new.portb = {27'h0000000, shamt};
      default:    w_new.portb = 32'h0000_0000;
    endcase
  end

  // in_ready depends only on registered skid state, never on out_ready.
  assign in_ready = !r_skid_valid;
  assign w_accept = in_valid && !r_skid_valid && !flush;
  assign w_xfer   = r_out_valid && out_ready;

  // Next-state for output register and skid entry.
  always_comb begin
    w_out_nxt        = r_out;
    w_out_valid_nxt  = r_out_valid;
    w_skid_nxt       = r_skid;
    w_skid_valid_nxt = r_skid_valid;
    if (flush) begin
      // Payload registers keep their values; only the valid bits are cleared.
      w_out_valid_nxt  = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (!r_out_valid || w_xfer) begin
      // Output register frees up this edge: refill from skid first (FIFO),
      // otherwise from the new accept. Accept cannot coincide with a full skid.
      if (r_skid_valid) begin
        w_out_nxt        = r_skid;
        w_out_valid_nxt  = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end else if (w_accept) begin
        w_out_nxt       = w_new;
        w_out_valid_nxt = 1'b1;
      end else begin
        w_out_valid_nxt = 1'b0;
      end
    end else begin
      // Output stalled: park the new instruction in the skid.
      if (w_accept) begin
        w_skid_nxt       = w_new;
        w_skid_valid_nxt = 1'b1;
      end else begin
        w_skid_valid_nxt = r_skid_valid;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
    end else begin
      r_out        <= w_out_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_skid       <= w_skid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
    end
  end

  alu_if u_alu_if ();

  assign u_alu_if.porta = r_out.porta;
  assign u_alu_if.portb = r_out.portb;
  assign u_alu_if.ALUOP = r_out.op;

  assign porta     = u_alu_if.porta;
  assign portb     = u_alu_if.portb;
  assign ALUOP     = u_alu_if.ALUOP;
  assign out_valid = r_out_valid;

endmodule
